// File: rtl/line_buf_pkg.sv
// Shared types for the line-buffer RAM controller.
// States, grant encoding and statistics width.
package line_buf_pkg;

  typedef enum logic {
    S_FILL,
    S_FULL
  } state_t;

  typedef enum logic [1:0] {
    G_NONE,
    G_WR,
    G_RD
  } grant_t;

  localparam int STAT_W = 16;

endpackage

// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter: writes first, but a pending read
// wins after MAX_WR_STREAK back-to-back write grants.
module ram_port_arbiter
  import line_buf_pkg::*;
#(
  parameter int MAX_WR_STREAK = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   fill,
  input  logic   wr_valid,
  input  logic   rd_req,
  output logic   wr_ready,
  output grant_t grant
);

  localparam int SW = $clog2(MAX_WR_STREAK + 1);

  logic [SW-1:0] streak;
  logic          at_limit;

  assign at_limit = (streak == SW'(MAX_WR_STREAK));
  assign wr_ready = rst_n && fill && !(rd_req && at_limit);

  // rst_n gating keeps every grant low while reset is held
  always_comb begin
    grant = G_NONE;
    if (wr_valid && wr_ready)
      grant = G_WR;
    else if (rd_req && rst_n)
      grant = G_RD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (!rd_req || grant == G_RD) begin
      streak <= '0;
    end else if (grant == G_WR && !at_limit) begin
      streak <= streak + 1'b1;
    end
  end

endmodule

// File: rtl/line_buf_ctrl.sv
// Line RAM controller: write pointer, fill/full FSM, read data.
// Define LINE_BUF_CTRL_STATS_EN to enable the read-stall counter.
module line_buf_ctrl
  import line_buf_pkg::*;
#(
  parameter int ADDR_WIDTH    = 6,
  parameter int DATA_WIDTH    = 30,
  parameter int LINE_WIDTH    = 64,
  parameter int MAX_WR_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_valid,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ready,
  input  logic                  i_rd_req,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic                  o_rd_ack,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_line_clr,
  output logic                  o_line_full,
  output logic                  o_line_done,
  output logic [ADDR_WIDTH-1:0] o_wr_ptr,
  output logic                  o_ram_cs,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_din,
  input  logic [DATA_WIDTH-1:0] i_ram_dout,
  output logic [STAT_W-1:0]     o_rd_stall_cnt
);

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(LINE_WIDTH - 1);

  state_t state;
  grant_t grant;
  logic   wg;
  logic   last_px;

  ram_port_arbiter #(
    .MAX_WR_STREAK(MAX_WR_STREAK)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .fill    (state == S_FILL),
    .wr_valid(i_wr_valid),
    .rd_req  (i_rd_req),
    .wr_ready(o_wr_ready),
    .grant   (grant)
  );

  assign wg          = (grant == G_WR);
  assign o_rd_ack    = (grant == G_RD);
  assign last_px     = wg && (o_wr_ptr == LAST);
  assign o_line_full = (state == S_FULL);

  always_comb begin
    o_ram_cs   = 1'b0;
    o_ram_we   = 1'b0;
    o_ram_addr = '0;
    o_ram_din  = '0;
    unique case (grant)
      G_WR: begin
        o_ram_cs   = 1'b1;
        o_ram_we   = 1'b1;
        o_ram_addr = o_wr_ptr;
        o_ram_din  = i_wr_data;
      end
      G_RD: begin
        o_ram_cs   = 1'b1;
        o_ram_addr = i_rd_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FILL;
      o_wr_ptr    <= '0;
      o_line_done <= 1'b0;
    end else begin
      o_line_done <= last_px;
      if (wg)
        o_wr_ptr <= last_px ? '0 : o_wr_ptr + 1'b1;
      unique case (state)
        S_FILL: if (last_px) state <= S_FULL;
        S_FULL: if (i_line_clr) state <= S_FILL;
        default: state <= S_FILL;
      endcase
    end
  end

  // RAM read is combinational, so the word is captured at the ack edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      o_rd_valid <= o_rd_ack;
      if (o_rd_ack)
        o_rd_data <= i_ram_dout;
    end
  end

`ifdef LINE_BUF_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rd_stall_cnt <= '0;
    end else if (i_rd_req && !o_rd_ack
                 && o_rd_stall_cnt != {STAT_W{1'b1}}) begin
      o_rd_stall_cnt <= o_rd_stall_cnt + 1'b1;
    end
  end
`else
  assign o_rd_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Directed testbench for line_buf_ctrl with a behavioural
// single-port RAM (combinational read, registered write).
module tb_line_buf_ctrl;

  localparam int AW = 6;
  localparam int DW = 30;

`ifdef LINE_BUF_CTRL_STATS_EN
  localparam int EXP_STALL = 4;
`else
  localparam int EXP_STALL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_wr_valid = 1'b0;
  logic [DW-1:0] i_wr_data = '0;
  logic          o_wr_ready;
  logic          i_rd_req = 1'b0;
  logic [AW-1:0] i_rd_addr = '0;
  logic          o_rd_ack;
  logic          o_rd_valid;
  logic [DW-1:0] o_rd_data;
  logic          i_line_clr = 1'b0;
  logic          o_line_full;
  logic          o_line_done;
  logic [AW-1:0] o_wr_ptr;
  logic          o_ram_cs;
  logic          o_ram_we;
  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_ram_din;
  logic [DW-1:0] i_ram_dout;
  logic [15:0]   o_rd_stall_cnt;

  logic [DW-1:0] mem [64];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (o_ram_cs && o_ram_we) mem[o_ram_addr] <= o_ram_din;

  assign i_ram_dout = mem[o_ram_addr];

  line_buf_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_wr_valid    (i_wr_valid),
    .i_wr_data     (i_wr_data),
    .o_wr_ready    (o_wr_ready),
    .i_rd_req      (i_rd_req),
    .i_rd_addr     (i_rd_addr),
    .o_rd_ack      (o_rd_ack),
    .o_rd_valid    (o_rd_valid),
    .o_rd_data     (o_rd_data),
    .i_line_clr    (i_line_clr),
    .o_line_full   (o_line_full),
    .o_line_done   (o_line_done),
    .o_wr_ptr      (o_wr_ptr),
    .o_ram_cs      (o_ram_cs),
    .o_ram_we      (o_ram_we),
    .o_ram_addr    (o_ram_addr),
    .o_ram_din     (o_ram_din),
    .i_ram_dout    (i_ram_dout),
    .o_rd_stall_cnt(o_rd_stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    repeat (2) @(posedge clk);
    #1;
    outs = {o_wr_ready, o_rd_ack, o_rd_valid, o_line_full,
            o_line_done, o_ram_cs, o_ram_we, 25'd0};
    n_chk++;
    if (outs !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_flags: got %h exp 0", outs);
    end
    n_chk++;
    if (o_wr_ptr !== 6'd0 || o_rd_data !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_regs: ptr %0d data %h exp 0", o_wr_ptr, o_rd_data);
    end
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (o_wr_ready !== 1'b1 || o_line_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready %b full %b exp 1 0",
               o_wr_ready, o_line_full);
    end
    tick();
  endtask

  task automatic test_fill();
    int dones = 0;
    for (int i = 0; i < 64; i++) begin
      i_wr_valid = 1'b1;
      i_wr_data  = DW'(i);
      #1;
      n_chk++;
      if (o_wr_ready !== 1'b1 || o_ram_we !== 1'b1
          || o_ram_addr !== AW'(i)) begin
        n_fail++;
        $display("FAIL fill_wr[%0d]: ready %b we %b addr %0d exp 1 1 %0d",
                 i, o_wr_ready, o_ram_we, o_ram_addr, i);
      end
      @(posedge clk);
      #1;
      if (o_line_done === 1'b1) dones++;
    end
    n_chk++;
    if (dones !== 1 || o_line_done !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_done: pulses %0d now %b exp 1 1", dones, o_line_done);
    end
    n_chk++;
    if (o_line_full !== 1'b1 || o_wr_ptr !== 6'd0) begin
      n_fail++;
      $display("FAIL fill_full: full %b ptr %0d exp 1 0", o_line_full, o_wr_ptr);
    end
    i_wr_data = 30'd64;
    #1;
    n_chk++;
    if (o_wr_ready !== 1'b0 || o_ram_cs !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_block65: ready %b cs %b exp 0 0", o_wr_ready, o_ram_cs);
    end
    tick();
    n_chk++;
    if (o_line_done !== 1'b0 || o_wr_ptr !== 6'd0) begin
      n_fail++;
      $display("FAIL fill_after: done %b ptr %0d exp 0 0", o_line_done, o_wr_ptr);
    end
    i_wr_valid = 1'b0;
  endtask

  task automatic test_full_reads();
    logic [AW-1:0] addrs [3];
    addrs[0] = 6'd0;
    addrs[1] = 6'd63;
    addrs[2] = 6'd31;
    for (int k = 0; k < 3; k++) begin
      i_rd_req  = 1'b1;
      i_rd_addr = addrs[k];
      #1;
      n_chk++;
      if (o_rd_ack !== 1'b1) begin
        n_fail++;
        $display("FAIL full_ack[%0d]: got %b exp 1", k, o_rd_ack);
      end
      tick();
      n_chk++;
      if (o_rd_valid !== 1'b1 || o_rd_data !== DW'(addrs[k])) begin
        n_fail++;
        $display("FAIL full_data[%0d]: valid %b data %0d exp 1 %0d",
                 k, o_rd_valid, o_rd_data, addrs[k]);
      end
    end
    i_rd_req = 1'b0;
    tick();
    n_chk++;
    if (o_rd_valid !== 1'b0 || o_rd_data !== 30'd31) begin
      n_fail++;
      $display("FAIL full_hold: valid %b data %0d exp 0 31", o_rd_valid, o_rd_data);
    end
  endtask

  task automatic test_clear();
    i_line_clr = 1'b1;
    i_wr_valid = 1'b1;
    i_wr_data  = 30'h111;
    #1;
    n_chk++;
    if (o_wr_ready !== 1'b0 || o_ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_same_cycle: ready %b we %b exp 0 0", o_wr_ready, o_ram_we);
    end
    tick();
    i_line_clr = 1'b0;
    #1;
    n_chk++;
    if (o_line_full !== 1'b0 || o_wr_ready !== 1'b1
        || o_ram_we !== 1'b1 || o_ram_addr !== 6'd0) begin
      n_fail++;
      $display("FAIL clr_next: full %b ready %b we %b addr %0d exp 0 1 1 0",
               o_line_full, o_wr_ready, o_ram_we, o_ram_addr);
    end
    tick();
    i_wr_valid = 1'b0;
    n_chk++;
    if (o_wr_ptr !== 6'd1) begin
      n_fail++;
      $display("FAIL clr_ptr: got %0d exp 1", o_wr_ptr);
    end
    i_rd_req  = 1'b1;
    i_rd_addr = 6'd0;
    tick();
    i_rd_req = 1'b0;
    n_chk++;
    if (o_rd_valid !== 1'b1 || o_rd_data !== 30'h111) begin
      n_fail++;
      $display("FAIL clr_readback: valid %b data %h exp 1 111", o_rd_valid, o_rd_data);
    end
  endtask

  task automatic test_streak();
    i_rd_req   = 1'b1;
    i_rd_addr  = 6'd5;
    i_wr_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_wr_data = DW'(100 + k);
      #1;
      n_chk++;
      if (o_wr_ready !== 1'b1 || o_rd_ack !== 1'b0
          || o_ram_addr !== AW'(1 + k)) begin
        n_fail++;
        $display("FAIL streak_wr[%0d]: ready %b ack %b addr %0d exp 1 0 %0d",
                 k, o_wr_ready, o_rd_ack, o_ram_addr, 1 + k);
      end
      tick();
    end
    #1;
    n_chk++;
    if (o_wr_ready !== 1'b0 || o_rd_ack !== 1'b1
        || o_ram_we !== 1'b0 || o_ram_addr !== 6'd5) begin
      n_fail++;
      $display("FAIL streak_rd: ready %b ack %b we %b addr %0d exp 0 1 0 5",
               o_wr_ready, o_rd_ack, o_ram_we, o_ram_addr);
    end
    tick();
    i_rd_req = 1'b0;
    n_chk++;
    if (o_rd_valid !== 1'b1 || o_rd_data !== 30'd5) begin
      n_fail++;
      $display("FAIL streak_data: valid %b data %0d exp 1 5", o_rd_valid, o_rd_data);
    end
    n_chk++;
    if (o_rd_stall_cnt !== 16'(EXP_STALL)) begin
      n_fail++;
      $display("FAIL stall_cnt: got %0d exp %0d", o_rd_stall_cnt, EXP_STALL);
    end
    i_wr_valid = 1'b0;
    #1;
    n_chk++;
    if (o_wr_ptr !== 6'd5 || o_wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL streak_ptr: ptr %0d ready %b exp 5 1", o_wr_ptr, o_wr_ready);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    i_wr_valid = 1'b1;
    i_wr_data  = 30'h2AAAAAAA;
    tick();
    i_wr_valid = 1'b0;
    i_rd_req   = 1'b1;
    i_rd_addr  = 6'd5;
    #1;
    n_chk++;
    if (o_rd_ack !== 1'b1 || i_ram_dout !== 30'h2AAAAAAA) begin
      n_fail++;
      $display("FAIL b2b_ack: ack %b ram %h exp 1 2aaaaaaa", o_rd_ack, i_ram_dout);
    end
    tick();
    i_rd_req = 1'b0;
    n_chk++;
    if (o_rd_valid !== 1'b1 || o_rd_data !== 30'h2AAAAAAA) begin
      n_fail++;
      $display("FAIL b2b_data: valid %b data %h exp 1 2aaaaaaa", o_rd_valid, o_rd_data);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] outs;
    i_wr_valid = 1'b1;
    for (int i = 6; i < 20; i++) begin
      i_wr_data = DW'(i);
      tick();
    end
    i_wr_valid = 1'b0;
    i_rd_req   = 1'b1;
    i_rd_addr  = 6'd3;
    tick();
    n_chk++;
    if (o_wr_ptr !== 6'd20 || o_rd_valid !== 1'b1 || o_rd_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: ptr %0d valid %b ack %b exp 20 1 1",
               o_wr_ptr, o_rd_valid, o_rd_ack);
    end
    rst_n = 1'b0;
    #1;
    outs = {o_wr_ready, o_rd_ack, o_rd_valid, o_line_full,
            o_line_done, o_ram_cs, o_ram_we, o_ram_addr, 19'd0};
    n_chk++;
    if (outs !== 32'd0 || o_wr_ptr !== 6'd0 || o_rd_data !== 30'd0
        || o_rd_stall_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL arst_clear: flags %h ptr %0d data %h stall %0d exp 0",
               outs, o_wr_ptr, o_rd_data, o_rd_stall_cnt);
    end
    i_rd_req = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    i_wr_valid = 1'b1;
    i_wr_data  = 30'hABC;
    #1;
    n_chk++;
    if (o_ram_we !== 1'b1 || o_ram_addr !== 6'd0) begin
      n_fail++;
      $display("FAIL arst_first_wr: we %b addr %0d exp 1 0", o_ram_we, o_ram_addr);
    end
    tick();
    i_wr_valid = 1'b0;
    n_chk++;
    if (o_wr_ptr !== 6'd1) begin
      n_fail++;
      $display("FAIL arst_ptr: got %0d exp 1", o_wr_ptr);
    end
    i_rd_req  = 1'b1;
    i_rd_addr = 6'd0;
    tick();
    i_rd_req = 1'b0;
    n_chk++;
    if (o_rd_valid !== 1'b1 || o_rd_data !== 30'hABC) begin
      n_fail++;
      $display("FAIL arst_readback: valid %b data %h exp 1 abc", o_rd_valid, o_rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_reads();
    test_clear();
    test_streak();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
